// File: rtl/shift_ram_fifo_if.sv
// Bus bundle for shift_ram_fifo_ctrl: FIFO user side plus the external shift RAM side.
// FLUSH exists only when SHIFT_RAM_FIFO_FLUSH_EN is defined.
interface shift_ram_fifo_if #(
    parameter int C_WIDTH      = 16,
    parameter int C_ADDR_WIDTH = 4
);
    logic                    WR_EN;
    logic [C_WIDTH-1:0]      WR_DATA;
    logic                    FULL;
    logic                    AFULL;
    logic                    RD_EN;
    logic [C_WIDTH-1:0]      RD_DATA;
    logic                    RD_VALID;
    logic [C_ADDR_WIDTH+1:0] COUNT;
    logic                    OVERFLOW;
    logic                    UNDERFLOW;
    logic [C_WIDTH-1:0]      SR_D;
    logic                    SR_CE;
    logic [C_ADDR_WIDTH-1:0] SR_A;
    logic [C_WIDTH-1:0]      SR_Q;
`ifdef SHIFT_RAM_FIFO_FLUSH_EN
    logic                    FLUSH;

    // Controller view.
    modport slave (
        input  WR_EN, WR_DATA, RD_EN, SR_Q, FLUSH,
        output FULL, AFULL, RD_DATA, RD_VALID, COUNT, OVERFLOW, UNDERFLOW,
               SR_D, SR_CE, SR_A
    );

    // User plus shift RAM view.
    modport master (
        output WR_EN, WR_DATA, RD_EN, SR_Q, FLUSH,
        input  FULL, AFULL, RD_DATA, RD_VALID, COUNT, OVERFLOW, UNDERFLOW,
               SR_D, SR_CE, SR_A
    );
`else
    // Controller view.
    modport slave (
        input  WR_EN, WR_DATA, RD_EN, SR_Q,
        output FULL, AFULL, RD_DATA, RD_VALID, COUNT, OVERFLOW, UNDERFLOW,
               SR_D, SR_CE, SR_A
    );

    // User plus shift RAM view.
    modport master (
        output WR_EN, WR_DATA, RD_EN, SR_Q,
        input  FULL, AFULL, RD_DATA, RD_VALID, COUNT, OVERFLOW, UNDERFLOW,
               SR_D, SR_CE, SR_A
    );
`endif
endinterface

// File: rtl/shift_ram_fifo_ctrl.sv
// FWFT FIFO controller around an external variable-tap shift RAM with a one-word output register.
// Optional synchronous FLUSH input is enabled by defining SHIFT_RAM_FIFO_FLUSH_EN.
module shift_ram_fifo_ctrl #(
    parameter int C_WIDTH        = 16,
    parameter int C_ADDR_WIDTH   = 4,
    parameter int C_DEPTH        = 16,
    parameter int C_AFULL_THRESH = 12
) (
    input  logic             CLK,
    input  logic             SCLR_N,
    shift_ram_fifo_if.slave  bus
);

    localparam int CNT_W   = C_ADDR_WIDTH + 1;
    localparam int COUNT_W = C_ADDR_WIDTH + 2;

    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(C_DEPTH);
    localparam logic [COUNT_W-1:0] AFULL_C = COUNT_W'(C_AFULL_THRESH);

    typedef enum logic [1:0] {
        EMPTY,   // nothing in RAM, output register empty
        PRIMED,  // nothing in RAM, output register holds a word
        STREAM,  // RAM partially filled
        FULLST   // RAM holds C_DEPTH words
    } state_t;

    state_t               state_q, state_next;
    logic [CNT_W-1:0]     cnt_q, cnt_next;
    logic                 rd_valid_q, rd_valid_next;
    logic [C_WIDTH-1:0]   rd_data_q;
    logic [COUNT_W-1:0]   count_q, count_next;
    logic                 afull_q;
    logic                 overflow_q;
    logic                 underflow_q;

    logic                 flush;
    logic                 full;
    logic                 wr_acc;
    logic                 pop;
    logic                 load;
    logic [C_ADDR_WIDTH-1:0] sr_a;

`ifdef SHIFT_RAM_FIFO_FLUSH_EN
    assign flush = bus.FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign full = (state_q == FULLST);

    // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
    always_comb begin
        // SR_CE must stay low during reset and flush so the RAM never shifts a discarded word.
        wr_acc        = bus.WR_EN & ~full & SCLR_N & ~flush;
        pop           = bus.RD_EN & rd_valid_q;
        load          = (~rd_valid_q | pop) & (cnt_q != '0);
        cnt_next      = cnt_q + CNT_W'(wr_acc) - CNT_W'(load);
        rd_valid_next = load | (rd_valid_q & ~pop);

        if (flush) begin
            cnt_next      = '0;
            rd_valid_next = 1'b0;
        end

        count_next = COUNT_W'(cnt_next) + COUNT_W'(rd_valid_next);

        if (cnt_next == DEPTH_C) begin
            state_next = FULLST;
        end else if (cnt_next != '0) begin
            state_next = STREAM;
        end else if (rd_valid_next) begin
            state_next = PRIMED;
        end else begin
            state_next = EMPTY;
        end
    end

    // Oldest stored word sits at tap cnt-1; the tap is read before this edge's shift.
    always_comb begin
        sr_a = '0;
        if (cnt_q != '0) begin
            sr_a = C_ADDR_WIDTH'(cnt_q - CNT_W'(1));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the shift RAM itself is never cleared; cnt=0 makes its contents unreachable.
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            cnt_q       <= cnt_next;
            rd_valid_q  <= rd_valid_next;
            count_q     <= count_next;
            afull_q     <= (count_next >= AFULL_C);
            overflow_q  <= bus.WR_EN & full & ~flush;
            underflow_q <= bus.RD_EN & ~rd_valid_q & ~flush;
            if (load && !flush) begin
                rd_data_q <= bus.SR_Q;
            end
        end
    end

    assign bus.FULL      = full;
    assign bus.AFULL     = afull_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.COUNT     = count_q;
    assign bus.OVERFLOW  = overflow_q;
    assign bus.UNDERFLOW = underflow_q;
    assign bus.SR_D      = bus.WR_DATA;
    assign bus.SR_CE     = wr_acc;
    assign bus.SR_A      = sr_a;

endmodule
